// File: rtl/frame_pkg.sv
// Frame definition shared by the optical link transmitter and receiver.
// Both ends import these constants so the frame layout is defined in one place.
package frame_pkg;

  localparam int SYNC_W = 6;
  localparam logic [SYNC_W-1:0] SYNC_PATTERN = 6'b111110;
  localparam int DATA_W = 8;
  localparam int TRAIL_W = 6;
  // One bit counter serves both the payload and the trailer field
  localparam int CNT_W = $clog2((DATA_W > TRAIL_W) ? DATA_W : TRAIL_W);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    TRAIL
  } rx_state_t;

endpackage

// File: rtl/frame_disassembly_if.sv
// Receive-side output bundle: recovered sample plus link status.
// The master modport drives the bundle; the slave modport is for the FIFO, LEDs and display.
interface frame_disassembly_if;

  logic [frame_pkg::DATA_W-1:0] data_out;
  logic                         data_valid;
  logic                         frame_err;
  logic                         locked;
  logic [15:0]                  frame_count;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output locked,
    output frame_count
  );

  modport slave (
    input data_out,
    input data_valid,
    input frame_err,
    input locked,
    input frame_count
  );

endinterface

// File: rtl/frame_disassembly_bit_sampler.sv
// Bit clock recovery: synchronises the raw line and produces one mid-bit sample strobe per line bit.
// Every transition restarts the phase counter, so the sample point re-centres on each edge.
module bit_sampler #(
  parameter int OVERSAMPLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sample_strobe,
  output logic sample_bit
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  // [0],[1] form the two-flop synchroniser; [2] is the delayed copy for edge detection
  logic [2:0]      pipe_reg;
  logic [PH_W-1:0] phase_reg;
  logic            line_edge;

  assign line_edge = pipe_reg[1] ^ pipe_reg[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_reg  <= '0;
      phase_reg <= '0;
    end else begin
      pipe_reg <= {pipe_reg[1:0], din};
      if (line_edge) begin
        phase_reg <= PH_ONE;
      end else if (phase_reg == PH_LAST) begin
        phase_reg <= '0;
      end else begin
        phase_reg <= phase_reg + PH_ONE;
      end
    end
  end

  assign sample_strobe = (phase_reg == PH_MID);
  assign sample_bit    = pipe_reg[1];

endmodule

// File: rtl/frame_disassembly.sv
// Optical receiver frame decoder: hunts for the sync header, captures the payload and
// checks the all-zero trailer, reporting good samples, framing errors and link lock.
module frame_disassembly
  import frame_pkg::*;
#(
  parameter int OVERSAMPLE  = 4,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  frame_disassembly_if.master  rx
);

  localparam int RUN_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_W - 1);

  logic sample_strobe;
  logic sample_bit;

  bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_sampler (
    .clk           (clk),
    .rst_n         (rst_n),
    .din           (din),
    .sample_strobe (sample_strobe),
    .sample_bit    (sample_bit)
  );

  rx_state_t         state_reg;
  logic [SYNC_W-1:0] hist_reg;
  logic [DATA_W-1:0] payload_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              trail_err_reg;
  logic [RUN_W-1:0]  run_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              data_valid_reg;
  logic              frame_err_reg;
  logic              locked_reg;
  logic [15:0]       frame_count_reg;

  logic [SYNC_W-1:0] hist_next;
  logic              frame_bad_next;
  logic [RUN_W-1:0]  run_next;

  always_comb begin
    hist_next      = {hist_reg[SYNC_W-2:0], sample_bit};
    frame_bad_next = trail_err_reg | sample_bit;
    run_next       = (run_reg == RUN_MAX) ? run_reg : run_reg + RUN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      hist_reg        <= '0;
      payload_reg     <= '0;
      bit_cnt_reg     <= '0;
      trail_err_reg   <= 1'b0;
      run_reg         <= '0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (sample_strobe) begin
        case (state_reg)
          HUNT: begin
            hist_reg <= hist_next;
            if (hist_next == SYNC_PATTERN) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            // LSB first: the first payload bit ends up in bit 0
            payload_reg <= {sample_bit, payload_reg[DATA_W-1:1]};
            if (bit_cnt_reg == DATA_LAST) begin
              state_reg     <= TRAIL;
              bit_cnt_reg   <= '0;
              trail_err_reg <= 1'b0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
          TRAIL: begin
            trail_err_reg <= frame_bad_next;
            if (bit_cnt_reg == TRAIL_LAST) begin
              // Clearing the history keeps trailer bits out of the next header match
              state_reg   <= HUNT;
              hist_reg    <= '0;
              bit_cnt_reg <= '0;
              if (frame_bad_next) begin
                frame_err_reg <= 1'b1;
                run_reg       <= '0;
                locked_reg    <= 1'b0;
              end else begin
                data_out_reg    <= payload_reg;
                data_valid_reg  <= 1'b1;
                frame_count_reg <= frame_count_reg + 16'd1;
                run_reg         <= run_next;
                if (run_next == RUN_MAX) begin
                  locked_reg <= 1'b1;
                end
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign rx.data_out    = data_out_reg;
  assign rx.data_valid  = data_valid_reg;
  assign rx.frame_err   = frame_err_reg;
  assign rx.locked      = locked_reg;
  assign rx.frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_disassembly.sv
// Self-checking bench for frame_disassembly: serialises frames onto din and scores every
// data_valid / frame_err strobe against an expected-result queue.
module tb_frame_disassembly;
  import frame_pkg::*;

  localparam int OS   = 4;
  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;

  always #20 clk = ~clk;

  frame_disassembly_if rx ();

  frame_disassembly #(
    .OVERSAMPLE  (OS),
    .LOCK_FRAMES (LOCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .rx    (rx)
  );

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    logic [15:0] count;
    logic        locked;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_count = '0;
  logic [7:0]  m_data = '0;
  logic        m_locked = 1'b0;
  int          m_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Spec-level model of one completed frame, evaluated when the frame is launched
  task automatic expect_frame(input logic bad, input logic [7:0] payload);
    exp_t e;
    if (bad) begin
      m_run    = 0;
      m_locked = 1'b0;
      e = '{is_err: 1'b1, data: m_data, count: m_count, locked: 1'b0};
    end else begin
      m_data  = payload;
      m_count = m_count + 16'd1;
      m_run   = (m_run < LOCK) ? m_run + 1 : LOCK;
      if (m_run == LOCK) m_locked = 1'b1;
      e = '{is_err: 1'b0, data: m_data, count: m_count, locked: m_locked};
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_count  = '0;
    m_data   = '0;
    m_locked = 1'b0;
    m_run    = 0;
  endtask

  task automatic send_bit(input logic b, input int n_clk);
    din = b;
    repeat (n_clk) @(negedge clk);
  endtask

  task automatic send_idle(input int n_bits);
    for (int i = 0; i < n_bits; i++) send_bit(1'b0, OS);
  endtask

  // jitter=1 alternates the bit period between 3 and 5 clocks
  task automatic send_frame(input logic [7:0] payload, input logic [5:0] trailer, input bit jitter);
    logic [SYNC_W-1:0] hdr;
    int k;
    hdr = SYNC_PATTERN;
    k = 0;
    expect_frame(|trailer, payload);
    for (int i = SYNC_W - 1; i >= 0; i--) begin
      send_bit(hdr[i], jitter ? ((k % 2 == 0) ? 3 : 5) : OS);
      k++;
    end
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(payload[i], jitter ? ((k % 2 == 0) ? 3 : 5) : OS);
      k++;
    end
    for (int i = TRAIL_W - 1; i >= 0; i--) begin
      send_bit(trailer[i], jitter ? ((k % 2 == 0) ? 3 : 5) : OS);
      k++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data_out"}, 32'(rx.data_out), 32'(m_data));
    check_eq({tag, "_data_valid"}, 32'(rx.data_valid), 0);
    check_eq({tag, "_frame_err"}, 32'(rx.frame_err), 0);
    check_eq({tag, "_locked"}, 32'(rx.locked), 32'(m_locked));
    check_eq({tag, "_frame_count"}, 32'(rx.frame_count), 32'(m_count));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
  endtask

  // Scoreboard: every output strobe must match the oldest outstanding expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rx.data_valid || rx.frame_err)) begin
        check_eq("valid_err_exclusive", 32'(rx.data_valid & rx.frame_err), 0);
        check_eq("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("strobe_kind_err", 32'(rx.frame_err), 32'(e.is_err));
          check_eq("data_out", 32'(rx.data_out), 32'(e.data));
          check_eq("frame_count", 32'(rx.frame_count), 32'(e.count));
          check_eq("locked", 32'(rx.locked), 32'(e.locked));
        end
        $display("rx %s data_out=%02h frame_count=%0d locked=%0b t=%0t",
                 rx.frame_err ? "frame_err " : "data_valid", rx.data_out,
                 rx.frame_count, rx.locked, $time);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d strobes outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("por");
    rst_n = 1'b1;
    send_idle(4);

    // Single frame, A5
    send_frame(8'hA5, 6'b000000, 1'b0);
    send_idle(4);

    // Fresh start so lock is reached on the fourth frame of the back-to-back run
    apply_reset();
    send_idle(4);
    send_frame(8'h00, 6'b000000, 1'b0);
    send_frame(8'hFF, 6'b000000, 1'b0);
    send_frame(8'h3C, 6'b000000, 1'b0);
    send_frame(8'h81, 6'b000000, 1'b0);

    // Trailer violation drops lock and keeps the last good sample
    send_frame(8'h99, 6'b000100, 1'b0);
    send_idle(4);
    check_idle_outputs("after_bad");

    // Jittered bit periods
    send_frame(8'h5A, 6'b000000, 1'b1);
    send_idle(4);

    // Reset after three payload bits of a frame
    for (int i = SYNC_W - 1; i >= 0; i--) send_bit((i != 0), OS);
    send_bit(1'b1, OS);
    send_bit(1'b0, OS);
    send_bit(1'b1, OS);
    apply_reset();
    send_idle(4);
    send_frame(8'h12, 6'b000000, 1'b0);
    send_idle(4);

    // frame_count wrap
    @(negedge clk);
    force dut.frame_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_reg;
    m_count = 16'hFFFF;
    @(negedge clk);
    check_eq("preload_count", 32'(rx.frame_count), 32'(m_count));
    send_frame(8'h77, 6'b000000, 1'b0);
    send_idle(6);

    check_eq("pending_strobes", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_disassembly.md
Name: frame_disassembly

Overview:
- Receive-side counterpart of frame_assembly. Sits on the optical receiver FPGA behind the photodiode input pin.
- Oversamples the incoming serial line, recovers bit timing and finds frame sync. Extracts one 8-bit audio sample per frame and presents it with a one-cycle valid strobe to the receive FIFO.
- Reports lock and framing errors for LEDs and the seven-segment display.

Parameters:
- OVERSAMPLE, 4, clk cycles per line bit. Must be ≥ 4; clk = 24.576 MHz for the 6.144 Mb/s line.
- SYNC_W, 6, sync header width in bits.
- SYNC_PATTERN, 6'b111110, header value, first-transmitted bit in MSB.
- DATA_W, 8, payload bits per frame, transmitted LSB first.
- TRAIL_W, 6, trailer width; every trailer bit must be 0.
- LOCK_FRAMES, 4, consecutive good frames required to assert locked.

Ports:
- clk  input  1  oversampling clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  raw serial line, asynchronous to clk
- data_out  output  DATA_W  last good payload, bit0 = first received payload bit
- data_valid  output  1  one-cycle strobe, data_out is new
- frame_err  output  1  one-cycle strobe, trailer check failed
- locked  output  1  LOCK_FRAMES good frames in a row seen
- frame_count  output  16  good frames since reset, wraps at 2^16

Behaviour:
- Reset, asynchronous, all outputs 0: data_out=0, data_valid=0, frame_err=0, locked=0, frame_count=0. State=HUNT, phase counter=0, synchronizer flops=0.
- Input path: 2-flop synchronizer on din, then one delay flop for edge detection. All logic uses the synchronized signal.
- Bit clock recovery: phase counter runs 0..OVERSAMPLE-1, and the sample strobe fires at phase OVERSAMPLE/2.
  - On any synchronized edge the counter reloads to 1, so the sample point re-centres every transition.
  - With no edge, the counter wraps to 0 after OVERSAMPLE-1.
- Sync detection: in HUNT, each sampled bit shifts into a SYNC_W history register. When the history equals SYNC_PATTERN on a sample strobe, go to DATA and clear the bit counter.
- DATA: shift DATA_W sampled bits into the payload register, LSB first. After the DATA_W-th bit, go to TRAIL.
- TRAIL: sample TRAIL_W bits.
  - A 1 on any trailer bit raises a sticky error flag for the frame.
  - After the last trailer bit, go to HUNT.
  - Good frame: data_out <= payload, data_valid=1 for exactly one clk, frame_count++, good-run counter++ (saturating at LOCK_FRAMES).
  - Bad frame: frame_err=1 for one clk, data_out unchanged, good-run counter=0, locked=0.
- Latency: data_valid fires 1 clk after the sample strobe of the last trailer bit.
- locked: asserts on the clk the good-run counter reaches LOCK_FRAMES. It stays high until a bad frame or reset. Loss of signal alone does not drop it.
- Back-to-back frames: the sync history register clears on the transition out of TRAIL. The next frame's header is therefore matched only from fresh bits, never from trailer bits.
- Payload mimicking sync: not checked mid-frame. In HUNT, a false match is rejected by the trailer check, and the block re-hunts.
- data_valid and frame_err are mutually exclusive and never asserted in the same cycle.
- frame_count wraps 16'hFFFF -> 0 with no flag.
- Reset mid-frame: immediate return to HUNT; the partial payload is discarded and no strobe is issued.
- A stuck line (no edges) keeps sampling at the free-running phase. In HUNT it never matches and produces no output.

Decomposition:
- Shared package frame_pkg: SYNC_W, SYNC_PATTERN, DATA_W, TRAIL_W, and the rx_state_t enum {HUNT, DATA, TRAIL}.
  - The same constants are reused by frame_assembly so both ends share one frame definition.
- One sub-module: bit_sampler (synchronizer, edge detect, phase counter). Outputs sample_strobe and sample_bit.
- Framing FSM, counters and output registers live in frame_disassembly.

Test Plan:
- Send one frame at OVERSAMPLE=4: header 111110, payload 8'hA5 sent LSB first (1,0,1,0,0,1,0,1), trailer 000000.
  -> data_valid pulses once, data_out=8'hA5, frame_count=1, frame_err stays 0.
- Send 4 back-to-back good frames with payloads 8'h00, 8'hFF, 8'h3C, 8'h81.
  -> Four data_valid strobes with those values in order; locked rises on the 4th strobe cycle.
- After lock, send a frame with trailer 000100.
  -> frame_err pulses once, no data_valid, data_out holds 8'h81, locked=0.
- Send a frame with a per-bit period alternating 3 and 5 clks (jitter).
  -> Payload 8'h5A still recovered exactly with no frame_err.
- Assert rst_n=0 after 3 payload bits of a frame, then release and send payload 8'h12.
  -> No strobe from the aborted frame; data_valid with 8'h12; frame_count=1.
- Preload frame_count to 16'hFFFF via 65535 good frames (or force), then send 1 good frame.
  -> frame_count=0 and data_valid pulses normally.
